// File: rtl/store_buffer_pkg.sv
// Shared definitions for the MEM-stage store path: store op codes, byte-enable constants, drain FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package store_buffer_pkg;

    // Store op codes, shared with the control unit
    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_SB   = 2'b01,
        ST_SH   = 2'b10,
        ST_SW   = 2'b11
    } st_op_t;

    // Byte-enable patterns for the data-memory write port
    localparam logic [3:0] BE_B0  = 4'b0001;
    localparam logic [3:0] BE_B1  = 4'b0010;
    localparam logic [3:0] BE_B2  = 4'b0100;
    localparam logic [3:0] BE_B3  = 4'b1000;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;

    // Drain FSM: IDLE exactly when the buffer holds nothing
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } sb_state_t;

    // One buffered store: word address, lane-replicated data, byte enables
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundles the MEM-stage store/load-probe signals and the data-memory write port of the store buffer.
// Latency: n/a (wires only).
// Backpressure: st_stall toward the pipeline, dm_req/dm_ack toward memory.
interface store_buffer_if;

    logic        st_valid;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_stall;
    logic        st_exc;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        sb_empty;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;

    // The store buffer itself
    modport slave (
        input  st_valid, st_op, st_addr, st_data, ld_addr, dm_ack,
        output st_stall, st_exc, ld_hit, sb_empty,
        output dm_req, dm_addr, dm_wdata, dm_be
    );

    // Pipeline plus data memory around the buffer
    modport master (
        output st_valid, st_op, st_addr, st_data, ld_addr, dm_ack,
        input  st_stall, st_exc, ld_hit, sb_empty,
        input  dm_req, dm_addr, dm_wdata, dm_be
    );

endinterface

// File: rtl/store_align.sv
// Store-side mirror of the load extender: op/addr/data -> byte enables, replicated write data, misalignment.
// Latency: purely combinational.
// Backpressure: none.
module store_align
    import store_buffer_pkg::*;
(
    input  st_op_t      op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned
);

    // Decode the lane pattern for each store width; ST_NONE yields all zeros
    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0;
        misaligned = 1'b0;
        case (op)
            ST_SB: begin
                be    = BE_B0 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            ST_SH: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? BE_HHI : BE_HLO;
                wdata      = {2{data[15:0]}};
            end
            ST_SW: begin
                misaligned = |addr_lo;
                be         = BE_W;
                wdata      = data;
            end
            default: begin
                be         = 4'b0000;
                wdata      = 32'h0;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: aligns sb/sh/sw, queues them, drains to data memory, flags loads that hit pending words.
// Latency: store accepted at edge N is presented on dm_req in cycle N+1; one write per acked cycle.
// Backpressure: st_stall while full (registered count only); head held stable until dm_ack.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  sb
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic          al_mis;

    logic          st_act;
    logic          full;
    logic          accept;
    logic          pop;

    sb_entry_t     entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    sb_state_t     state;
    sb_state_t     state_nxt;

    logic          dm_req_o;
    logic [31:0]   dm_addr_o;
    logic [31:0]   dm_wdata_o;
    logic [3:0]    dm_be_o;
    logic          ld_hit_o;
    logic          ld_lo_unused;

    store_align u_align (
        .op         (st_op_t'(sb.st_op)),
        .addr_lo    (sb.st_addr[1:0]),
        .data       (sb.st_data),
        .be         (al_be),
        .wdata      (al_wdata),
        .misaligned (al_mis)
    );

    // Store-side decisions; full comes from the registered count so a same-cycle ack cannot lift the stall
    assign st_act      = sb.st_valid & (sb.st_op != ST_NONE);
    assign full        = (count == FULL_CNT);
    assign accept      = st_act & ~al_mis & ~full;
    assign sb.st_stall = st_act & ~al_mis & full;
    assign sb.st_exc   = st_act & al_mis;

    // An ack only counts while the head is actually being presented
    assign pop = (state == DRAIN) & sb.dm_ack;

    // Entry storage: written at the tail on accept, no reset needed since valid bits guard it
    always_ff @(posedge clk) begin
        if (accept) begin
            entries[wr_ptr] <= '{waddr: sb.st_addr[31:2], wdata: al_wdata, be: al_be};
        end
    end

    // Pointers, occupancy and per-entry valid bits; push and pop in one cycle leave count unchanged
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (accept) begin
                wr_ptr        <= wr_ptr + 1'b1;
                valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                valid[rd_ptr] <= 1'b0;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain FSM next state: leave DRAIN only when the last entry pops with nothing arriving
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && !accept && (count == ONE_CNT)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Drain FSM outputs: present the head entry while draining, drive zeros when idle
    always_comb begin
        dm_req_o   = 1'b0;
        dm_addr_o  = 32'h0;
        dm_wdata_o = 32'h0;
        dm_be_o    = 4'b0000;
        if (state == DRAIN) begin
            dm_req_o   = 1'b1;
            dm_addr_o  = {entries[rd_ptr].waddr, 2'b00};
            dm_wdata_o = entries[rd_ptr].wdata;
            dm_be_o    = entries[rd_ptr].be;
        end
    end

    // Load probe: any valid entry to the same word hits, including the one popping this cycle
    always_comb begin
        ld_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].waddr == sb.ld_addr[31:2])) begin
                ld_hit_o = 1'b1;
            end
        end
    end

    // Byte offset of the load is irrelevant to a word-granular hit
    assign ld_lo_unused = ^sb.ld_addr[1:0];

    assign sb.dm_req   = dm_req_o;
    assign sb.dm_addr  = dm_addr_o;
    assign sb.dm_wdata = dm_wdata_o;
    assign sb.dm_be    = dm_be_o;
    assign sb.ld_hit   = ld_hit_o;
    assign sb.sb_empty = (count == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus a random store/ack stream against a queue-and-byte-memory model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 2 units later.
// Backpressure: ack gaps are randomised; stalls are predicted from model occupancy.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if sbi ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbi)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    ent_t pending;
    logic [7:0] mem_model [int unsigned];
    logic [7:0] mem_dut   [int unsigned];

    logic        exp_exc, exp_stall, exp_acc, exp_req, exp_hit, exp_empty;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    // Reference model: expected outputs from the pending-store queue and the current inputs
    function automatic void model_eval();
        logic       act;
        logic       mis;
        logic [3:0] be;
        logic [31:0] wd;
        act = sbi.st_valid && (sbi.st_op != 2'b00);
        mis = 1'b0;
        be  = 4'h0;
        wd  = 32'h0;
        case (sbi.st_op)
            2'b01: begin
                case (sbi.st_addr[1:0])
                    2'd0: be = 4'h1;
                    2'd1: be = 4'h2;
                    2'd2: be = 4'h4;
                    default: be = 4'h8;
                endcase
                wd = {24'h0, sbi.st_data[7:0]} * 32'h01010101;
            end
            2'b10: begin
                mis = sbi.st_addr[0];
                be  = sbi.st_addr[1] ? 4'hC : 4'h3;
                wd  = {16'h0, sbi.st_data[15:0]} * 32'h00010001;
            end
            2'b11: begin
                mis = (sbi.st_addr[1:0] != 2'b00);
                be  = 4'hF;
                wd  = sbi.st_data;
            end
            default: ;
        endcase
        pending   = '{sbi.st_addr[31:2], wd, be};
        exp_exc   = act && mis;
        exp_stall = act && !mis && (q.size() >= DEPTH);
        exp_acc   = act && !mis && (q.size() < DEPTH);
        exp_req   = (q.size() != 0);
        exp_empty = (q.size() == 0);
        exp_addr  = exp_req ? {q[0].wa, 2'b00} : 32'h0;
        exp_wdata = exp_req ? q[0].wd : 32'h0;
        exp_be    = exp_req ? q[0].be : 4'h0;
        exp_hit   = 1'b0;
        foreach (q[i]) if (q[i].wa == sbi.ld_addr[31:2]) exp_hit = 1'b1;
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] ld, input logic ack);
        reset        = rst;
        sbi.st_valid = v;
        sbi.st_op    = op;
        sbi.st_addr  = a;
        sbi.st_data  = d;
        sbi.ld_addr  = ld;
        sbi.dm_ack   = ack;
        #2;
        model_eval();
    endtask

    // Record what the DUT writes, advance the model across the edge, then move to the next cycle
    task automatic tick();
        if (reset && sbi.dm_req && sbi.dm_ack) begin
            for (int b = 0; b < 4; b++)
                if (sbi.dm_be[b]) mem_dut[sbi.dm_addr + b] = sbi.dm_wdata[8*b +: 8];
        end
        if (!reset) begin
            q.delete();
        end else begin
            if (sbi.dm_ack && q.size() > 0) begin
                for (int b = 0; b < 4; b++)
                    if (q[0].be[b]) mem_model[{q[0].wa, 2'b00} + b] = q[0].wd[8*b +: 8];
                void'(q.pop_front());
            end
            if (exp_acc) q.push_back(pending);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 1, 2'b10, 32'h2001, 32'h0, 32'h0, 0);
        n_vec++; if (sbi.st_exc !== 1'b1) begin n_err++; $display("FAIL rst_exc got %b want 1", sbi.st_exc); end
        n_vec++; if (sbi.st_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", sbi.st_stall); end
        tick();
        drive(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0);
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0);
        n_vec++; if ({sbi.dm_req, sbi.dm_addr, sbi.dm_wdata, sbi.dm_be} !== 69'h0) begin
            n_err++; $display("FAIL rst_dm got req=%b addr=%h wd=%h be=%b want all zero",
                              sbi.dm_req, sbi.dm_addr, sbi.dm_wdata, sbi.dm_be); end
        n_vec++; if ({sbi.sb_empty, sbi.ld_hit, sbi.st_stall, sbi.st_exc} !== 4'b1000) begin
            n_err++; $display("FAIL rst_flags got empty/hit/stall/exc=%b want 1000",
                              {sbi.sb_empty, sbi.ld_hit, sbi.st_stall, sbi.st_exc}); end
        tick();
    endtask

    task automatic test_sb();
        drive(1, 1, 2'b01, 32'h1003, 32'h000000A5, 32'h0, 1);
        n_vec++; if ({sbi.st_exc, sbi.st_stall, sbi.dm_req} !== 3'b000) begin
            n_err++; $display("FAIL sb_accept got exc/stall/req=%b want 000", {sbi.st_exc, sbi.st_stall, sbi.dm_req}); end
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1);
        n_vec++; if ({sbi.dm_req, sbi.dm_addr, sbi.dm_be, sbi.dm_wdata} !== {1'b1, 32'h1000, 4'b1000, 32'hA5A5A5A5}) begin
            n_err++; $display("FAIL sb_present got req=%b addr=%h be=%b wd=%h want 1 00001000 1000 a5a5a5a5",
                              sbi.dm_req, sbi.dm_addr, sbi.dm_be, sbi.dm_wdata); end
        n_vec++; if (sbi.sb_empty !== 1'b0) begin n_err++; $display("FAIL sb_busy got empty=%b want 0", sbi.sb_empty); end
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0);
        n_vec++; if ({sbi.sb_empty, sbi.dm_req} !== 2'b10) begin
            n_err++; $display("FAIL sb_drained got empty/req=%b want 10", {sbi.sb_empty, sbi.dm_req}); end
        tick();
    endtask

    task automatic test_sh();
        drive(1, 1, 2'b10, 32'h2001, 32'h00001234, 32'h0, 0);
        n_vec++; if ({sbi.st_exc, sbi.st_stall} !== 2'b10) begin
            n_err++; $display("FAIL sh_misalign got exc/stall=%b want 10", {sbi.st_exc, sbi.st_stall}); end
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0);
        n_vec++; if ({sbi.dm_req, sbi.sb_empty} !== 2'b01) begin
            n_err++; $display("FAIL sh_discard got req/empty=%b want 01", {sbi.dm_req, sbi.sb_empty}); end
        drive(1, 1, 2'b10, 32'h2002, 32'h00001234, 32'h0, 0);
        n_vec++; if (sbi.st_exc !== 1'b0) begin n_err++; $display("FAIL sh_aligned got exc=%b want 0", sbi.st_exc); end
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1);
        n_vec++; if ({sbi.dm_req, sbi.dm_addr, sbi.dm_be, sbi.dm_wdata} !== {1'b1, 32'h2000, 4'b1100, 32'h12341234}) begin
            n_err++; $display("FAIL sh_present got req=%b addr=%h be=%b wd=%h want 1 00002000 1100 12341234",
                              sbi.dm_req, sbi.dm_addr, sbi.dm_be, sbi.dm_wdata); end
        tick();
    endtask

    task automatic test_stall();
        drive(1, 1, 2'b11, 32'h4000, 32'h11111111, 32'h0, 0);
        n_vec++; if (sbi.st_stall !== 1'b0) begin n_err++; $display("FAIL stall_first got %b want 0", sbi.st_stall); end
        tick();
        drive(1, 1, 2'b11, 32'h4004, 32'h22222222, 32'h0, 0);
        n_vec++; if (sbi.st_stall !== 1'b0) begin n_err++; $display("FAIL stall_second got %b want 0", sbi.st_stall); end
        tick();
        drive(1, 1, 2'b11, 32'h4008, 32'h33333333, 32'h0, 0);
        n_vec++; if (sbi.st_stall !== 1'b1) begin n_err++; $display("FAIL stall_full got %b want 1", sbi.st_stall); end
        tick();
        drive(1, 1, 2'b11, 32'h4008, 32'h33333333, 32'h0, 1);
        n_vec++; if ({sbi.st_stall, sbi.dm_req, sbi.dm_addr} !== {2'b11, 32'h4000}) begin
            n_err++; $display("FAIL stall_ack got stall=%b req=%b addr=%h want 1 1 00004000",
                              sbi.st_stall, sbi.dm_req, sbi.dm_addr); end
        tick();
        drive(1, 1, 2'b11, 32'h4008, 32'h33333333, 32'h0, 0);
        n_vec++; if ({sbi.st_stall, sbi.dm_addr} !== {1'b0, 32'h4004}) begin
            n_err++; $display("FAIL stall_release got stall=%b addr=%h want 0 00004004", sbi.st_stall, sbi.dm_addr); end
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1);
        n_vec++; if (sbi.dm_wdata !== 32'h22222222) begin n_err++; $display("FAIL stall_head2 got %h want 22222222", sbi.dm_wdata); end
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1);
        n_vec++; if ({sbi.dm_addr, sbi.dm_wdata} !== {32'h4008, 32'h33333333}) begin
            n_err++; $display("FAIL stall_head3 got addr=%h wd=%h want 00004008 33333333", sbi.dm_addr, sbi.dm_wdata); end
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0);
        n_vec++; if (sbi.sb_empty !== 1'b1) begin n_err++; $display("FAIL stall_drained got empty=%b want 1", sbi.sb_empty); end
        tick();
    endtask

    task automatic test_ld_hit();
        drive(1, 1, 2'b11, 32'h3000, 32'hCAFEF00D, 32'h0, 0);
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h3002, 0);
        n_vec++; if (sbi.ld_hit !== 1'b1) begin n_err++; $display("FAIL hit_same_word got %b want 1", sbi.ld_hit); end
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h3004, 0);
        n_vec++; if (sbi.ld_hit !== 1'b0) begin n_err++; $display("FAIL hit_next_word got %b want 0", sbi.ld_hit); end
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h3002, 1);
        n_vec++; if (sbi.ld_hit !== 1'b1) begin n_err++; $display("FAIL hit_popping got %b want 1", sbi.ld_hit); end
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h3002, 0);
        n_vec++; if (sbi.ld_hit !== 1'b0) begin n_err++; $display("FAIL hit_after_pop got %b want 0", sbi.ld_hit); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 2'b11, 32'h5000, 32'h55555555, 32'h0, 0);
        tick();
        drive(1, 1, 2'b11, 32'h5004, 32'h66666666, 32'h0, 0);
        tick();
        drive(0, 0, 2'b00, 32'h0, 32'h0, 32'h5000, 0);
        n_vec++; if (sbi.dm_req !== 1'b1) begin n_err++; $display("FAIL midrst_before got req=%b want 1", sbi.dm_req); end
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h5000, 1);
        n_vec++; if ({sbi.dm_req, sbi.sb_empty, sbi.ld_hit} !== 3'b010) begin
            n_err++; $display("FAIL midrst_after got req/empty/hit=%b want 010", {sbi.dm_req, sbi.sb_empty, sbi.ld_hit}); end
        tick();
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h5004, 1);
        n_vec++; if ({sbi.dm_req, sbi.ld_hit} !== 2'b00) begin
            n_err++; $display("FAIL midrst_ack got req/hit=%b want 00", {sbi.dm_req, sbi.ld_hit}); end
        tick();
        n_vec++; if (mem_dut.exists(32'h5000) || mem_dut.exists(32'h5004)) begin
            n_err++; $display("FAIL midrst_nowrite got a write to 0x5000/0x5004 want none"); end
    endtask

    task automatic test_random();
        logic        v;
        logic [1:0]  op;
        logic [31:0] a, d, ld;
        logic        ack;
        for (int c = 0; c < 400; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            op  = 2'($urandom_range(0, 3));
            a   = 32'h8000 + $urandom_range(0, 31);
            d   = $urandom;
            ld  = 32'h8000 + $urandom_range(0, 31);
            ack = ($urandom_range(0, 4) < 2);
            drive(1, v, op, a, d, ld, ack);
            n_vec++; if ({sbi.st_exc, sbi.st_stall} !== {exp_exc, exp_stall}) begin
                n_err++; $display("FAIL rnd_store c=%0d got exc/stall=%b%b want %b%b", c,
                                  sbi.st_exc, sbi.st_stall, exp_exc, exp_stall); end
            n_vec++; if ({sbi.dm_req, sbi.sb_empty} !== {exp_req, exp_empty}) begin
                n_err++; $display("FAIL rnd_req c=%0d got req/empty=%b%b want %b%b", c,
                                  sbi.dm_req, sbi.sb_empty, exp_req, exp_empty); end
            n_vec++; if ({sbi.dm_addr, sbi.dm_wdata, sbi.dm_be} !== {exp_addr, exp_wdata, exp_be}) begin
                n_err++; $display("FAIL rnd_head c=%0d got %h/%h/%b want %h/%h/%b", c,
                                  sbi.dm_addr, sbi.dm_wdata, sbi.dm_be, exp_addr, exp_wdata, exp_be); end
            n_vec++; if (sbi.ld_hit !== exp_hit) begin
                n_err++; $display("FAIL rnd_hit c=%0d got %b want %b", c, sbi.ld_hit, exp_hit); end
            tick();
        end
        for (int c = 0; c < DEPTH + 2; c++) begin
            drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1);
            tick();
        end
        drive(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0);
        n_vec++; if (sbi.sb_empty !== 1'b1) begin n_err++; $display("FAIL rnd_drained got empty=%b want 1", sbi.sb_empty); end
        n_vec++; if (mem_dut.size() != mem_model.size()) begin
            n_err++; $display("FAIL rnd_memsize got %0d bytes want %0d", mem_dut.size(), mem_model.size()); end
        foreach (mem_model[k]) begin
            n_vec++;
            if (!mem_dut.exists(k)) begin
                n_err++; $display("FAIL rnd_mem addr=%h got unwritten want %h", k, mem_model[k]);
            end else if (mem_dut[k] !== mem_model[k]) begin
                n_err++; $display("FAIL rnd_mem addr=%h got %h want %h", k, mem_dut[k], mem_model[k]);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_sb();
        test_sh();
        test_stall();
        test_ld_hit();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store-side counterpart of the load-data extender in the MEM stage. Takes sb/sh/sw requests, generates the byte-enable and lane-replicated write data, and checks alignment. Accepted stores go into a small in-order FIFO, which drains to the data-memory write port over a req/ack handshake. Pending stores to a word are reported to the load path so a load never reads stale memory.

## Interface
Parameters:
- DEPTH, 2, number of buffer entries; power of two, ≥2

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- st_valid  in  1  MEM stage presents a store this cycle
- st_op  in  2  00 none, 01 sb, 10 sh, 11 sw
- st_addr  in  32  byte address of store
- st_data  in  32  rt value, right-aligned
- st_stall  out  1  store valid but buffer full; hold MEM stage
- st_exc  out  1  misaligned store (AdES); store discarded
- ld_addr  in  32  byte address of load in MEM stage
- ld_hit  out  1  a buffered store targets the same word as ld_addr
- sb_empty  out  1  no buffered stores
- dm_req  out  1  head entry presented to data memory
- dm_addr  out  32  word address {addr[31:2],2'b00}
- dm_wdata  out  32  lane-replicated write data
- dm_be  out  4  byte enables
- dm_ack  in  1  memory accepted head entry this cycle

## Operation
- Alignment (combinational, on st_addr/st_data):
  - sb: BE = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - sh: addr[0] must be 0; BE = addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - sw: addr[1:0] must be 00; BE = 1111; wdata = data.
- Misaligned store: st_exc = st_valid & (op≠00) & misaligned. It is asserted in the same cycle, the store is not enqueued, and st_stall stays 0.
- Accept: st_valid & op≠00 & aligned & !full writes {word addr, wdata, BE} at tail on the clock edge.
- st_stall = st_valid & op≠00 & aligned & full. Full is taken from the registered count only: an ack in the same cycle does not lift the stall.
- st_op = 00 or st_valid = 0: no effect.
- Drain FSM:
  - IDLE (count 0): dm_req = 0 and dm_addr/wdata/be = 0. Go to DRAIN when an entry is written.
  - DRAIN: dm_req = 1 and outputs come from the head entry. They stay stable until dm_ack. On dm_ack the head is popped.
  - After a pop, go to IDLE if count becomes 0; otherwise the next entry is presented the following cycle with dm_req held high.
- Simultaneous push and pop: count unchanged, both pointers advance.
- dm_ack while dm_req = 0: ignored.
- ld_hit is combinational: OR over valid entries of (entry word addr == ld_addr[31:2]). The entry being popped in the current cycle still counts as a hit.
- sb_empty = (count == 0).

## Timing
- Reset (reset = 0 at a clock edge):
  - Count, pointers and FSM go to IDLE.
  - dm_req = 0, dm_addr/dm_wdata/dm_be = 0, sb_empty = 1, ld_hit = 0.
  - st_stall and st_exc follow their combinational definitions.
- Reset mid-drain: all entries are discarded, dm_req falls after that edge, and a later dm_ack is ignored.
- Latency: a store accepted at edge N into an empty buffer gives dm_req = 1 in cycle N+1. If memory acks in N+1, sb_empty = 1 in N+2.
- Throughput: one store per cycle in, one write per acked cycle out.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.

## Structure
- Shared package:
  - ST_NONE/ST_SB/ST_SH/ST_SW op codes (shared with the control unit).
  - BE_B0..BE_B3, BE_HLO, BE_HHI, BE_W constants.
  - FSM state encoding IDLE/DRAIN.
- Sub-module store_align: purely combinational op/addr/data → {be, wdata, misaligned}. It is the store-side mirror of the load extender and is instantiated once.

## Test plan
- sb to 0x1003, data 0x000000A5, buffer empty, ack held 1 → next cycle dm_req = 1, dm_addr 0x1000, dm_be 1000, dm_wdata 0xA5A5A5A5; sb_empty = 1 two cycles later.
- sh to 0x2001 → st_exc = 1 that cycle, st_stall = 0, no dm_req; sh to 0x2002, data 0x1234 → dm_be 1100, dm_wdata 0x12341234.
- DEPTH = 2, ack held 0, three sw back-to-back → first two accepted, third sees st_stall = 1. Raising ack in the same cycle still stalls; the third is accepted the cycle after the first ack.
- Buffered sw to 0x3000, ld_addr 0x3002 → ld_hit = 1; ld_addr 0x3004 → ld_hit = 0; ld_hit drops the cycle after the entry's ack.
- Two entries pending, reset low for one edge mid-drain, dm_ack pulsed afterward → dm_req = 0, sb_empty = 1, no further writes.
- Random sb/sh/sw stream with random ack gaps against a byte-array memory model → memory contents and write order match exactly.
